data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Responder side of the core's data-SRAM interface. It accepts load/store requests issued by the execute stage and returns one `data_ram_data_ready` pulse per request, loads and stores alike, strictly in order.
- Loads return the raw 32-bit word; the memory stage does byte/half/left/right extraction. Stores are acknowledged so the consumer's outstanding-store counter drains.
- Contains the word-addressed backing array, a response queue with programmable minimum latency, and a hold input for back-pressure/latency injection in benches.

Parameters:
- INDEX_WIDTH, 12, log2 of array depth in 32-bit words; word index = request_address[INDEX_WIDTH+1:2].
- READ_LATENCY, 1, minimum cycles from acceptance to response; legal range 1..15.
- QUEUE_DEPTH, 4, maximum outstanding (accepted, unresponded) requests; power of two, at least 2.

Ports:
- clock  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- request_valid  input  1  request present this cycle.
- request_ready  output  1  responder can accept a request this cycle.
- request_write  input  1  1 = store, 0 = load.
- request_strobe  input  4  byte-write enables, bit i covers bits [8i+7:8i]; ignored for loads.
- request_address  input  32  byte address; bits [1:0] and bits above INDEX_WIDTH+1 are ignored.
- request_write_data  input  32  store data, already lane-aligned.
- response_hold  input  1  when 1, no response is delivered this cycle.
- data_ram_read_data  output  32  load word for the current response; holds its last value otherwise.
- data_ram_data_ready  output  1  one-cycle pulse per response, loads and stores.

Behaviour:
- Reset state: `request_ready`=0, `data_ram_data_ready`=0, `data_ram_read_data`=0, queue count=0, head/tail pointers=0. Array contents are not reset.
- `request_ready` = !reset_q && count < QUEUE_DEPTH, where reset_q is a 1-cycle registered copy of reset, so ready is 0 in the first cycle after reset deasserts.
  - Ready is registered-count based only: a pop in the same cycle does not free a slot for that cycle.
- Accept when request_valid && request_ready.
  - Store: array write with byte strobes commits at the accept clock edge. The queue entry records is_write=1 with data 0.
  - Load: reads the array combinationally at accept, so it sees all stores accepted in earlier cycles. The queue entry records the word.
- Each queue entry carries a 4-bit age counter.
  - Age is 0 at push and increments each cycle, saturating at READ_LATENCY.
  - The head is deliverable when age == READ_LATENCY-1 or later and response_hold == 0.
- Delivery is registered. In the cycle after the head is deliverable:
  - `data_ram_data_ready`=1;
  - `data_ram_read_data` = entry data for loads; unchanged for stores.
  - The entry pops on the deliverable cycle.
- Net timing: accept at cycle N gives a pulse at N+READ_LATENCY when nothing older is pending and hold is low.
- At most one response per cycle. Back-to-back accepts give back-to-back pulses.
- Responses are strictly FIFO; store acks and load data are never reordered.
- Simultaneous push and pop: count unchanged; both pointers advance modulo QUEUE_DEPTH with wrap-around.
- response_hold=1: the head stays, ages saturate, and the queue may fill. Acceptance stops at count == QUEUE_DEPTH.
- Reset mid-operation: all queued responses are discarded and no pulse is emitted for them. Stores committed before reset persist in the array.
- A pulse scheduled for the reset cycle is suppressed.
- The array is written only on accepted stores; nothing else writes it.

Test Plan:
- READ_LATENCY=1: store 0x0000_1000 ← 0xDEADBEEF, strobe 1111, at cycle N, then load 0x1000 at N+1 → pulses at N+1 and N+2; read_data=0xDEADBEEF at N+2.
- Byte strobes: word 0x2000 initialised to 0, store 0x11223344 with strobe 0010, then load 0x2003 → read_data=0x00003300 (low address bits ignored).
- Full queue: response_hold=1, issue 5 loads to distinct pre-written words A–E → ready low after the 4th accept, 5th not accepted, no pulses. Drop hold → A–D data on 4 consecutive pulses in order, then E accepted.
- READ_LATENCY=3: single load accepted at cycle 10 → pulse exactly at cycle 13 and only then. Three back-to-back loads at 10,11,12 → pulses at 13,14,15.
- Reset with 3 outstanding loads plus an earlier store of 0x5A5A5A5A to 0x40 → no pulse from reset through 5 cycles after; ready=0 during reset and the next cycle, then 1. Subsequent load of 0x40 returns 0x5A5A5A5A.
- Aliasing: store 0xCAFEF00D to 0x0000_0010, then load 0x0000_4010 with INDEX_WIDTH=12 → returns 0xCAFEF00D.

Source files
------------

// File: rtl/data_ram_responder_if.sv
// Load/store request bus between the execute stage and the data-SRAM responder.
// The master drives requests and response hold; the slave returns ready, pulses and load data.
interface data_ram_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [3:0]  request_strobe;
    logic [31:0] request_address;
    logic [31:0] request_write_data;
    logic        response_hold;
    logic [31:0] data_ram_read_data;
    logic        data_ram_data_ready;

    modport master (
        output request_valid, request_write, request_strobe, request_address,
               request_write_data, response_hold,
        input  request_ready, data_ram_read_data, data_ram_data_ready
    );

    modport slave (
        input  request_valid, request_write, request_strobe, request_address,
               request_write_data, response_hold,
        output request_ready, data_ram_read_data, data_ram_data_ready
    );
endinterface

// File: rtl/data_ram_responder.sv
// Data-SRAM responder: word array plus an in-order response queue; one ready pulse per request, READ_LATENCY cycles min.
// Back-pressure: request_ready drops when QUEUE_DEPTH requests are outstanding; response_hold stalls delivery.
module data_ram_responder #(
    parameter int INDEX_WIDTH  = 12,
    parameter int READ_LATENCY = 1,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    data_ram_responder_if.slave  bus
);
    localparam int         DEPTH  = 1 << INDEX_WIDTH;
    localparam int         PW     = $clog2(QUEUE_DEPTH);
    localparam int         CW     = PW + 1;
    localparam logic [3:0] LAT    = 4'(READ_LATENCY);
    localparam bit         BYPASS = (READ_LATENCY == 1);

    logic [31:0]   r_mem     [DEPTH];
    logic [31:0]   r_q_data  [QUEUE_DEPTH];
    logic          r_q_write [QUEUE_DEPTH];
    logic [3:0]    r_q_age   [QUEUE_DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_reset_q;
    logic          r_data_ready;
    logic [31:0]   r_read_data;

    logic                   w_ready;
    logic                   w_accept;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [31:0]            w_load_word;
    logic                   w_head_vld;
    logic                   w_head_aged;
    logic                   w_pop_queue;
    logic                   w_pop_bypass;
    logic                   w_pop;
    logic                   w_pop_write;
    logic [31:0]            w_pop_data;
    logic [CW-1:0]          w_count_next;
    logic                   w_unused;

    assign w_unused = ^{bus.request_address[31:INDEX_WIDTH+2], bus.request_address[1:0]};

    assign w_ready  = !reset && !r_reset_q && (r_count < CW'(QUEUE_DEPTH));
    assign w_accept = bus.request_valid && w_ready;
    assign w_index  = bus.request_address[INDEX_WIDTH+1:2];

    // Read happens before this edge's store commits, so a load sees only earlier-cycle stores.
    assign w_load_word = r_mem[w_index];

    // Stored age is the age the entry has in the current cycle; compare age+1 in 5 bits to avoid wrap.
    assign w_head_vld   = (r_count != '0);
    assign w_head_aged  = ({1'b0, r_q_age[r_head]} + 5'd1) >= {1'b0, LAT};
    assign w_pop_queue  = w_head_vld && w_head_aged && !bus.response_hold;
    // With unit latency an accept into an empty queue is deliverable in its own cycle.
    assign w_pop_bypass = BYPASS && !w_head_vld && w_accept && !bus.response_hold;
    assign w_pop        = w_pop_queue || w_pop_bypass;
    assign w_pop_write  = w_pop_queue ? r_q_write[r_head] : bus.request_write;
    assign w_pop_data   = w_pop_queue ? r_q_data[r_head]  : w_load_word;

    assign w_count_next = r_count + {{PW{1'b0}}, w_accept} - {{PW{1'b0}}, w_pop};

    always_ff @(posedge clock) begin
        if (w_accept && bus.request_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.request_strobe[b]) begin
                    r_mem[w_index][8*b +: 8] <= bus.request_write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (w_accept && (r_tail == PW'(i))) begin
                r_q_age[i]   <= 4'd1;
                r_q_write[i] <= bus.request_write;
                r_q_data[i]  <= bus.request_write ? 32'd0 : w_load_word;
            end else if (r_q_age[i] < LAT) begin
                r_q_age[i] <= r_q_age[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        r_reset_q <= reset;
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_data_ready <= 1'b0;
            r_read_data  <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count      <= w_count_next;
            r_data_ready <= w_pop;
            if (w_pop && !w_pop_write) begin
                r_read_data <= w_pop_data;
            end
        end
    end

    assign bus.request_ready       = w_ready;
    assign bus.data_ram_data_ready = r_data_ready && !reset;
    assign bus.data_ram_read_data  = r_read_data;
endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: one unit-latency instance and one READ_LATENCY=3 instance.
module tb_data_ram_responder;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset1;
    logic reset3;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    data_ram_responder_if if1();
    data_ram_responder_if if3();

    data_ram_responder #(.INDEX_WIDTH(12), .READ_LATENCY(1), .QUEUE_DEPTH(4)) dut1 (
        .clock (clock),
        .reset (reset1),
        .bus   (if1)
    );

    data_ram_responder #(.INDEX_WIDTH(12), .READ_LATENCY(3), .QUEUE_DEPTH(4)) dut3 (
        .clock (clock),
        .reset (reset3),
        .bus   (if3)
    );

    int          p1_cyc[$];
    logic [31:0] p1_dat[$];
    int          p3_cyc[$];
    logic [31:0] p3_dat[$];

    always @(negedge clock) begin
        if (if1.data_ram_data_ready === 1'b1) begin
            p1_cyc.push_back(cyc);
            p1_dat.push_back(if1.data_ram_read_data);
        end
        if (if3.data_ram_data_ready === 1'b1) begin
            p3_cyc.push_back(cyc);
            p3_dat.push_back(if3.data_ram_read_data);
        end
    end

    task automatic req1(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clock);
        if1.request_valid      = 1'b1;
        if1.request_write      = w;
        if1.request_strobe     = s;
        if1.request_address    = a;
        if1.request_write_data = d;
        while (if1.request_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL req1_accept addr=%h: ready stayed low for %0d cycles, required high", a, n);
        end
        acc = cyc;
    endtask

    task automatic req3(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clock);
        if3.request_valid      = 1'b1;
        if3.request_write      = w;
        if3.request_strobe     = s;
        if3.request_address    = a;
        if3.request_write_data = d;
        while (if3.request_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL req3_accept addr=%h: ready stayed low for %0d cycles, required high", a, n);
        end
        acc = cyc;
    endtask

    task automatic idle1(input int n);
        @(negedge clock);
        if1.request_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic idle3(input int n);
        @(negedge clock);
        if3.request_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if (if1.request_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", if1.request_ready); end
        checks++;
        if (if1.data_ram_data_ready !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", if1.data_ram_data_ready); end
        checks++;
        if (if1.data_ram_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", if1.data_ram_read_data); end
        reset1 = 1'b0;
        reset3 = 1'b0;
        #1;
        checks++;
        if (if1.request_ready !== 1'b0) begin errors++; $display("FAIL ready_first_cycle got=%b exp=0", if1.request_ready); end
        @(negedge clock);
        checks++;
        if (if1.request_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", if1.request_ready); end
        checks++;
        if (if3.request_ready !== 1'b1) begin errors++; $display("FAIL ready3_after_reset got=%b exp=1", if3.request_ready); end
    endtask

    task automatic test_store_load;
        int a0, a1;
        p1_cyc.delete(); p1_dat.delete();
        req1(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, a0);
        req1(1'b0, 4'hF, 32'h0000_1000, 32'h0, a1);
        idle1(4);
        #1;
        checks++;
        if (a1 !== a0 + 1) begin errors++; $display("FAIL sl_accept_b2b got=%0d exp=%0d", a1, a0 + 1); end
        checks++;
        if (p1_cyc.size() !== 2) begin errors++; $display("FAIL sl_pulse_count got=%0d exp=2", p1_cyc.size()); end
        else begin
            checks++;
            if (p1_cyc[0] !== a0 + 1) begin errors++; $display("FAIL sl_store_ack_cycle got=%0d exp=%0d", p1_cyc[0], a0 + 1); end
            checks++;
            if (p1_cyc[1] !== a0 + 2) begin errors++; $display("FAIL sl_load_cycle got=%0d exp=%0d", p1_cyc[1], a0 + 2); end
            checks++;
            if (p1_dat[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sl_load_data got=%h exp=deadbeef", p1_dat[1]); end
        end
    endtask

    task automatic test_strobes;
        int a;
        p1_cyc.delete(); p1_dat.delete();
        req1(1'b1, 4'hF,    32'h0000_2000, 32'h0,         a);
        req1(1'b1, 4'b0010, 32'h0000_2000, 32'h1122_3344, a);
        req1(1'b0, 4'hF,    32'h0000_2003, 32'h0,         a);
        idle1(4);
        #1;
        checks++;
        if (p1_cyc.size() !== 3) begin errors++; $display("FAIL strb_pulse_count got=%0d exp=3", p1_cyc.size()); end
        else begin
            checks++;
            if (p1_dat[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL strb_store_holds_rdata got=%h exp=deadbeef", p1_dat[0]); end
            checks++;
            if (p1_dat[2] !== 32'h0000_3300) begin errors++; $display("FAIL strb_byte1 got=%h exp=00003300", p1_dat[2]); end
        end
    endtask

    task automatic test_aliasing;
        int a;
        p1_cyc.delete(); p1_dat.delete();
        req1(1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, a);
        req1(1'b0, 4'hF, 32'h0000_4010, 32'h0,         a);
        idle1(4);
        #1;
        checks++;
        if (p1_dat.size() !== 2) begin errors++; $display("FAIL alias_pulse_count got=%0d exp=2", p1_dat.size()); end
        else begin
            checks++;
            if (p1_dat[1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL alias_data got=%h exp=cafef00d", p1_dat[1]); end
        end
    endtask

    task automatic test_full_queue;
        logic [31:0] vals [5];
        int a, h;
        vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
        vals[3] = 32'hD0D0_0004; vals[4] = 32'hE0E0_0005;
        for (int i = 0; i < 5; i++) req1(1'b1, 4'hF, 32'h100 + 32'(4 * i), vals[i], a);
        idle1(4);
        #1;
        p1_cyc.delete(); p1_dat.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) if1.response_hold = 1'b1;
            if1.request_valid   = 1'b1;
            if1.request_write   = 1'b0;
            if1.request_address = 32'h100 + 32'(4 * i);
            checks++;
            if (if1.request_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready_%0d got=%b exp=%b", i, if1.request_ready, (i < 4));
            end
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (p1_cyc.size() !== 0) begin errors++; $display("FAIL full_no_pulse_on_hold got=%0d exp=0", p1_cyc.size()); end
        checks++;
        if (if1.request_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held got=%b exp=0", if1.request_ready); end
        @(negedge clock);
        if1.response_hold = 1'b0;
        h = cyc;
        @(negedge clock);
        checks++;
        if (if1.request_ready !== 1'b1) begin errors++; $display("FAIL full_e_ready got=%b exp=1", if1.request_ready); end
        idle1(8);
        #1;
        checks++;
        if (p1_cyc.size() !== 5) begin errors++; $display("FAIL full_pulse_count got=%0d exp=5", p1_cyc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (p1_dat[i] !== vals[i] || p1_cyc[i] !== h + 1 + i) begin
                    errors++;
                    $display("FAIL full_resp_%0d got=%h@%0d exp=%h@%0d", i, p1_dat[i], p1_cyc[i], vals[i], h + 1 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int a;
        req1(1'b1, 4'hF, 32'h0000_0040, 32'h5A5A_5A5A, a);
        idle1(3);
        #1;
        p1_cyc.delete(); p1_dat.delete();
        if1.response_hold = 1'b1;
        for (int i = 0; i < 3; i++) req1(1'b0, 4'hF, 32'h100 + 32'(4 * i), 32'h0, a);
        idle1(1);
        @(negedge clock);
        reset1 = 1'b1;
        if1.response_hold = 1'b0;
        #1;
        checks++;
        if (if1.request_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset got=%b exp=0", if1.request_ready); end
        @(negedge clock);
        reset1 = 1'b0;
        #1;
        checks++;
        if (if1.request_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_after got=%b exp=0", if1.request_ready); end
        @(negedge clock);
        #1;
        checks++;
        if (if1.request_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_back got=%b exp=1", if1.request_ready); end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (p1_cyc.size() !== 0) begin errors++; $display("FAIL rmid_no_pulse got=%0d exp=0", p1_cyc.size()); end
        req1(1'b0, 4'hF, 32'h0000_0040, 32'h0, a);
        idle1(4);
        #1;
        checks++;
        if (p1_dat.size() !== 1 || p1_dat[0] !== 32'h5A5A_5A5A || p1_cyc[0] !== a + 1) begin
            errors++;
            $display("FAIL rmid_store_persists count=%0d exp=1, data/cycle exp=5a5a5a5a@%0d", p1_dat.size(), a + 1);
        end
    endtask

    task automatic test_latency3;
        logic [31:0] vals [3];
        int a, a0, a1, a2;
        vals[0] = 32'h1234_5678; vals[1] = 32'h9ABC_DEF0; vals[2] = 32'h0F1E_2D3C;
        for (int i = 0; i < 3; i++) req3(1'b1, 4'hF, 32'h8 + 32'(4 * i), vals[i], a);
        idle3(8);
        #1;
        p3_cyc.delete(); p3_dat.delete();
        req3(1'b0, 4'hF, 32'h8, 32'h0, a);
        idle3(7);
        #1;
        checks++;
        if (p3_cyc.size() !== 1) begin errors++; $display("FAIL lat3_single_count got=%0d exp=1", p3_cyc.size()); end
        else begin
            checks++;
            if (p3_cyc[0] !== a + 3) begin errors++; $display("FAIL lat3_single_cycle got=%0d exp=%0d", p3_cyc[0], a + 3); end
            checks++;
            if (p3_dat[0] !== vals[0]) begin errors++; $display("FAIL lat3_single_data got=%h exp=%h", p3_dat[0], vals[0]); end
        end
        p3_cyc.delete(); p3_dat.delete();
        req3(1'b0, 4'hF, 32'h8, 32'h0, a0);
        req3(1'b0, 4'hF, 32'hC, 32'h0, a1);
        req3(1'b0, 4'hF, 32'h10, 32'h0, a2);
        idle3(8);
        #1;
        checks++;
        if (a2 !== a0 + 2) begin errors++; $display("FAIL lat3_b2b_accept got=%0d exp=%0d", a2, a0 + 2); end
        checks++;
        if (p3_cyc.size() !== 3) begin errors++; $display("FAIL lat3_b2b_count got=%0d exp=3", p3_cyc.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (p3_cyc[i] !== a0 + 3 + i || p3_dat[i] !== vals[i]) begin
                    errors++;
                    $display("FAIL lat3_b2b_%0d got=%h@%0d exp=%h@%0d", i, p3_dat[i], p3_cyc[i], vals[i], a0 + 3 + i);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset1 = 1'b1;
        reset3 = 1'b1;
        if1.request_valid = 1'b0; if1.request_write = 1'b0; if1.request_strobe = 4'h0;
        if1.request_address = 32'h0; if1.request_write_data = 32'h0; if1.response_hold = 1'b0;
        if3.request_valid = 1'b0; if3.request_write = 1'b0; if3.request_strobe = 4'h0;
        if3.request_address = 32'h0; if3.request_write_data = 32'h0; if3.response_hold = 1'b0;
        test_reset();
        test_store_load();
        test_strobes();
        test_aliasing();
        test_full_queue();
        test_reset_mid();
        test_latency3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
